// File: rtl/comparator_pkg.sv
// Shared constants for the comparator: result flag bit positions, flag vector
// width and the default operand width.
package comparator_pkg;

  localparam int RESULT_W      = 8;
  localparam int DEFAULT_WIDTH = 8;

  localparam int EQ_BIT  = 0;
  localparam int NE_BIT  = 1;
  localparam int LTU_BIT = 2;
  localparam int GTU_BIT = 3;
  localparam int LTS_BIT = 4;
  localparam int GTS_BIT = 5;
  localparam int AZ_BIT  = 6;
  localparam int BZ_BIT  = 7;

endpackage : comparator_pkg

// File: rtl/comparator_core.sv
// Purely combinational flag generator: compares a and b both as unsigned
// magnitudes and as two's-complement values, plus zero detection.
module comparator_core
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [RESULT_W-1:0] flags
);

  logic w_eq;
  logic w_ltu;
  logic w_lts;

  assign w_eq  = (a == b);
  assign w_ltu = (a < b);
  assign w_lts = ($signed(a) < $signed(b));

  // NOTE: every bit of a combinational output gets a default first, so no
  // path through the block can leave a bit unassigned and infer a latch.
  always_comb begin
    flags          = '0;
    flags[EQ_BIT]  = w_eq;
    flags[NE_BIT]  = ~w_eq;
    flags[LTU_BIT] = w_ltu;
    flags[GTU_BIT] = ~w_ltu & ~w_eq;
    flags[LTS_BIT] = w_lts;
    flags[GTS_BIT] = ~w_lts & ~w_eq;
    flags[AZ_BIT]  = (a == '0);
    flags[BZ_BIT]  = (b == '0);
  end

endmodule : comparator_core

// File: rtl/comparator.sv
// Registered comparator: captures the flag vector of a/b whenever in_valid is
// high. Define COMPARATOR_MINMAX_EN to add registered unsigned max_u/min_u.
module comparator
  import comparator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [RESULT_W-1:0] result,
  output logic                out_valid
`ifdef COMPARATOR_MINMAX_EN
  ,
  output logic [WIDTH-1:0]    max_u,
  output logic [WIDTH-1:0]    min_u
`endif
);

  logic [RESULT_W-1:0] w_flags;
  logic [RESULT_W-1:0] r_result;
  logic                r_out_valid;

  comparator_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (a),
    .b     (b),
    .flags (w_flags)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_result    <= w_flags;
      r_out_valid <= 1'b1;
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;

`ifdef COMPARATOR_MINMAX_EN
  logic [WIDTH-1:0] r_max_u;
  logic [WIDTH-1:0] r_min_u;

  // On equality both select a, which is the required tie value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max_u <= '0;
      r_min_u <= '0;
    end else if (in_valid) begin
      r_max_u <= w_flags[LTU_BIT] ? b : a;
      r_min_u <= w_flags[GTU_BIT] ? b : a;
    end
  end

  assign max_u = r_max_u;
  assign min_u = r_min_u;
`endif

endmodule : comparator

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator (WIDTH=8); min/max checks are
// active when COMPARATOR_MINMAX_EN is defined.
module tb_comparator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       out_valid;
`ifdef COMPARATOR_MINMAX_EN
  logic [7:0] max_u;
  logic [7:0] min_u;
`endif

  int n_cmp = 0;
  int n_err = 0;

  comparator #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
`ifdef COMPARATOR_MINMAX_EN
    ,
    .max_u     (max_u),
    .min_u     (min_u)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one operand pair, check the flags one edge later.
  task automatic apply(input string tag, input logic [7:0] va,
                       input logic [7:0] vb, input logic [7:0] exp);
    @(negedge clk);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_result"}, result, exp);
    check({tag, "_valid"}, out_valid, 1'b1);
`ifdef COMPARATOR_MINMAX_EN
    check({tag, "_max"}, max_u, (va >= vb) ? va : vb);
    check({tag, "_min"}, min_u, (va <= vb) ? va : vb);
`endif
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #3;
    check("rst_result", result, 8'h00);
    check("rst_valid", out_valid, 1'b0);

    // Sample offered while reset is held must be discarded.
    @(negedge clk);
    a        = 8'h2F;
    b        = 8'h81;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("rst_discard_result", result, 8'h00);
    check("rst_discard_valid", out_valid, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // First sample after reset; still old value before the capturing edge.
    @(negedge clk);
    a        = 8'h2F;
    b        = 8'h81;
    in_valid = 1'b1;
    #1;
    check("pre_edge_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("v023_result", result, 8'h26);
    check("v023_valid", out_valid, 1'b1);
`ifdef COMPARATOR_MINMAX_EN
    check("v027_max", max_u, 8'h81);
    check("v027_min", min_u, 8'h2F);
`endif

    // Back-to-back samples, including sign-bit boundaries.
    apply("v024",    8'h80, 8'h00, 8'h9A);
    apply("v025",    8'h00, 8'h00, 8'hC1);
    apply("ff_01",   8'hFF, 8'h01, 8'h1A);
    apply("01_ff",   8'h01, 8'hFF, 8'h26);
    apply("ff_ff",   8'hFF, 8'hFF, 8'h01);
    apply("00_80",   8'h00, 8'h80, 8'h66);
    apply("05_00",   8'h05, 8'h00, 8'hAA);
    apply("80_7f",   8'h80, 8'h7F, 8'h1A);
    apply("v026",    8'h7F, 8'h80, 8'h26);

    // Hold with in_valid low while operands keep changing.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'h00;
    b        = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d_result", i), result, 8'h26);
      check($sformatf("hold%0d_valid", i), out_valid, 1'b1);
      @(negedge clk);
      a = a + 8'h11;
    end

    // Asynchronous reset between edges while in_valid is high.
    @(negedge clk);
    a        = 8'h2F;
    b        = 8'h81;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_result", result, 8'h00);
    check("async_rst_valid", out_valid, 1'b0);
`ifdef COMPARATOR_MINMAX_EN
    check("async_rst_max", max_u, 8'h00);
    check("async_rst_min", min_u, 8'h00);
`endif
    @(posedge clk);
    #1;
    check("async_hold_result", result, 8'h00);
    check("async_hold_valid", out_valid, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    a     = 8'h80;
    b     = 8'h00;
    #1;
    check("post_rst_pre_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_result", result, 8'h9A);
    check("post_rst_valid", out_valid, 1'b1);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_comparator

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operands on a/b are sampled this cycle.
REQ-005 Port: a  input  WIDTH  operand A, two's-complement or unsigned.
REQ-006 Port: b  input  WIDTH  operand B, same encoding.
REQ-007 Port: result  output  8  registered comparison flag vector; see REQ-010.
REQ-008 Port: out_valid  output  1  result holds the comparison of the most recent sampled pair.

Function
REQ-009 When in_valid=1 at a rising clk edge, the block SHALL capture the comparison of a and b into result and set out_valid=1; latency is exactly 1 cycle.
REQ-010 result bit map: [0] EQ a==b; [1] NE a!=b; [2] LTU a<b unsigned; [3] GTU a>b unsigned; [4] LTS a<b signed; [5] GTS a>b signed; [6] AZ a==0; [7] BZ b==0.
REQ-011 Signed flags SHALL treat bit WIDTH-1 as the sign bit; unsigned flags SHALL treat all bits as magnitude.
REQ-012 Exactly one of EQ, LTU, GTU SHALL be set, and exactly one of EQ, LTS, GTS SHALL be set; NE SHALL equal the inverse of EQ.
REQ-013 When in_valid=0, result and out_valid SHALL hold their previous values; out_valid stays 1 once set until reset.
REQ-014 Back-to-back in_valid=1 cycles SHALL each produce a result one cycle later, with no bubbles.
REQ-015 Inputs are not registered before comparison; the comparison logic is purely combinational from a/b to the result register.

Reset
REQ-016 rst_n=0 SHALL immediately force result=8'h00 and out_valid=0, regardless of clk.
REQ-017 A sample with in_valid=1 coinciding with an active reset SHALL be discarded.
REQ-018 The first sample SHALL be taken on the first rising edge after rst_n deasserts.

Configuration
REQ-019 Macro COMPARATOR_MINMAX_EN: when defined, the block SHALL add outputs max_u and min_u (WIDTH bits each), registered with result. max_u is the unsigned larger operand and min_u the unsigned smaller one. Both SHALL equal a when a==b and SHALL reset to 0.
REQ-020 Without COMPARATOR_MINMAX_EN, the ports in REQ-019 and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-021 Package comparator_pkg SHALL hold the result bit-index constants (EQ_BIT..BZ_BIT), the result width constant (8), and the default WIDTH.
REQ-022 One sub-module, comparator_core, SHALL be used: combinational, WIDTH-parameterized, producing the 8-bit flag vector. The top level SHALL contain only the registers, handshake and optional min/max.

Verification
REQ-023 Reset then a=8'h2F, b=8'h81, in_valid=1 -> next cycle result=8'b00100110, out_valid=1.
REQ-024 a=8'h80, b=8'h00 -> result=8'b10011010 (signed less, unsigned greater).
REQ-025 a=8'h00, b=8'h00 -> result=8'b11000001.
REQ-026 a=8'h7F, b=8'h80, then in_valid=0 for 3 cycles -> result=8'b00100110 on the capture cycle and held unchanged for all 3 cycles.
REQ-027 With COMPARATOR_MINMAX_EN defined: a=8'h2F, b=8'h81 -> max_u=8'h81, min_u=8'h2F.
REQ-028 rst_n asserted mid-stream, between clock edges, while in_valid=1 -> result=0 and out_valid=0 immediately. The first valid output appears one cycle after the first post-reset sample.
